switch_debounce_ctrl: RTL

SWITCH_DEBOUNCE_CTRL -- requirements
Module: switch_debounce_ctrl

---
 rtl/switch_debounce_ctrl_if.sv | 26 ++
 rtl/switch_debounce_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/switch_debounce_ctrl_if.sv
// Switch controller CPU-side bus: decoder chip select, read strobe,
// register select, registered read data and the change interrupt.
// The CPU side uses the master modport; the controller uses slave.
interface switch_debounce_ctrl_if;
    logic        switchcs;
    logic        switchread;
    logic [2:0]  switchaddr;
    logic [15:0] switchrdata;
    logic        switch_irq;

    modport master (
        output switchcs,
        output switchread,
        output switchaddr,
        input  switchrdata,
        input  switch_irq
    );

    modport slave (
        input  switchcs,
        input  switchread,
        input  switchaddr,
        output switchrdata,
        output switch_irq
    );
endinterface

// File: rtl/switch_debounce_ctrl.sv
// Board switch controller: synchronises raw switches, optionally debounces
// them, latches a change flag plus a mask of changed low bits, and exposes
// everything through a small read-only register map.
// Define SWITCH_DEBOUNCE_EN to require DB_LIMIT stable cycles before a new
// switch value is accepted; without it the synchronised value is taken
// every cycle.
// All state updates on the falling edge of switclk.
module switch_debounce_ctrl #(
    parameter int SW_W     = 24,
    parameter int DB_LIMIT = 500000,
    parameter int DB_CNT_W = 20
) (
    input  logic                   switclk,
    input  logic                   switrst,
    input  logic [SW_W-1:0]        switch_i,
    switch_debounce_ctrl_if.slave  bus
);

    logic [SW_W-1:0] sync1;
    logic [SW_W-1:0] sync2;
    logic [SW_W-1:0] stable;
    logic [SW_W-1:0] diff;
    logic [31:0]     stable_ext;
    logic            commit;
    logic            chg;
    logic [15:0]     chg_mask;
    logic [15:0]     rdata;
    logic            rd_en;
    logic            flag_clr;

    assign rd_en      = bus.switchcs && bus.switchread;
    assign flag_clr   = rd_en && ((bus.switchaddr == 3'b100) || (bus.switchaddr == 3'b110));
    assign stable_ext = 32'(stable);

    // Two-flop synchroniser so nothing downstream sees a metastable input.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= switch_i;
            sync2 <= sync1;
        end
    end

`ifdef SWITCH_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] CNT_MAX = DB_CNT_W'(DB_LIMIT - 1);

    logic [SW_W-1:0]     cand;
    logic [DB_CNT_W-1:0] cnt;

    // Track the latest candidate value and how long it has stayed put; the
    // counter saturates so a long-held value never wraps into a recount.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sync2 != cand) begin
            cand <= sync2;
            cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + DB_CNT_W'(1);
        end
    end

    assign commit = (cnt == CNT_MAX) && (sync2 == cand) && (cand != stable);
    assign diff   = cand ^ stable;

    // Accept the candidate only once it has been stable long enough.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            stable <= '0;
        end else if (commit) begin
            stable <= cand;
        end
    end
`else
    assign commit = (sync2 != stable);
    assign diff   = sync2 ^ stable;

    // No debounce: the synchronised value becomes the accepted value directly.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            stable <= '0;
        end else begin
            stable <= sync2;
        end
    end
`endif

    // Change flag and accumulated change mask; a new change beats a clearing
    // read on the same edge so no event is ever lost.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            chg      <= 1'b0;
            chg_mask <= '0;
        end else if (commit) begin
            chg      <= 1'b1;
            chg_mask <= flag_clr ? diff[15:0] : (chg_mask | diff[15:0]);
        end else if (flag_clr) begin
            chg      <= 1'b0;
            chg_mask <= '0;
        end
    end

    // Registered read port; unmapped addresses and idle cycles hold the data.
    always_ff @(negedge switclk or posedge switrst) begin
        if (switrst) begin
            rdata <= '0;
        end else if (rd_en) begin
            case (bus.switchaddr)
                3'b000:  rdata <= stable_ext[15:0];
                3'b010:  rdata <= stable_ext[31:16];
                3'b100:  rdata <= {15'b0, chg};
                3'b110:  rdata <= chg_mask;
                default: rdata <= rdata;
            endcase
        end
    end

    assign bus.switchrdata = rdata;
    assign bus.switch_irq  = chg;

endmodule
